// File: rtl/bus_pkg.sv
// Shared encodings for the data-memory responder: transfer sizes, FSM states,
// default I/O addresses and the byte-lane steering helpers.
package bus_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam logic [31:0] STDOUT_ADDR_DEFAULT = 32'hf000_0000;
    localparam logic [31:0] EXIT_ADDR_DEFAULT   = 32'hff00_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESP   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    // Misaligned halfwords and words ignore the low address bits.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] ofs);
        if (size[1]) return 4'b0001 << ofs;
        if (size == SIZE_HALF) return ofs[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size[1]) return {4{d[7:0]}};
        if (size == SIZE_HALF) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] ofs,
                                               input logic [31:0] w);
        logic [31:0] sh;
        if (size[1]) begin
            sh = w >> {ofs, 3'b000};
            return {24'h0, sh[7:0]};
        end
        if (size == SIZE_HALF) begin
            sh = w >> {ofs[1], 4'b0000};
            return {16'h0, sh[15:0]};
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte enables: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM window plus stdout/exit ports behind a fixed-latency
// request/acknowledge handshake.
//
// state     | meaning
// ST_IDLE   | waiting for MREQ; latches the request on acceptance
// ST_WAIT   | counting down the remaining latency
// ST_RESP   | ACKD_n low for one cycle; store side effects on the closing edge
// ST_HALTED | exit store seen; no further acknowledges until reset
module dmem_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] DMEM_START  = 32'h0800_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] STDOUT_ADDR = STDOUT_ADDR_DEFAULT,
    parameter logic [31:0] EXIT_ADDR   = EXIT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DAD,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DDT_I,
    output logic [31:0] DDT_O,
    output logic        DDT_OE,
    output logic        ACKD_n,
    output logic        stdout_valid,
    output logic [7:0]  stdout_char,
    output logic        halt,
    output logic        addr_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_LO   = {1'b0, DMEM_START};
    localparam logic [32:0] WIN_HI   = WIN_LO + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        halt_q, addr_err_q;
    logic        accept, resp, in_win, is_stdout, is_exit, ram_we;
    logic [31:0] ram_off, ram_rdata;
    logic [AW-1:0] ram_addr;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign in_win    = ({1'b0, addr_q} >= WIN_LO) && ({1'b0, addr_q} < WIN_HI);
    assign is_stdout = (addr_q == STDOUT_ADDR);
    assign is_exit   = (addr_q == EXIT_ADDR);
    assign resp      = (state_q == ST_RESP);
    assign ram_off   = addr_q - DMEM_START;
    assign ram_addr  = AW'(ram_off >> 2);
    assign ram_we    = resp && write_q && in_win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MREQ && !halt_q) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_RESP;
            end
            ST_RESP:   state_d = (write_q && is_exit) ? ST_HALTED : ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            write_q    <= 1'b0;
            size_q     <= SIZE_WORD;
            halt_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= DAD;
                wdata_q <= DDT_I;
                write_q <= WRITE;
                size_q  <= SIZE;
            end
            if (resp && write_q && is_exit) halt_q <= 1'b1;
            if (resp && !in_win && !is_stdout && !is_exit) addr_err_q <= 1'b1;
        end
    end

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (lane_enable(size_q, addr_q[1:0])),
        .addr  (ram_addr),
        .wdata (lane_wdata(size_q, wdata_q)),
        .rdata (ram_rdata)
    );

    assign ACKD_n       = !resp;
    assign DDT_OE       = resp && !write_q;
    assign DDT_O        = (DDT_OE && in_win) ? lane_rdata(size_q, addr_q[1:0], ram_rdata) : 32'h0;
    assign stdout_valid = resp && write_q && is_stdout && size_q[1];
    assign stdout_char  = stdout_valid ? wdata_q[7:0] : 8'h00;
    assign halt         = halt_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1 (a_*) and one at
// LATENCY=3 (b_*), sharing clock and reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] a_dad = '0, a_ddt_i = '0, a_ddt_o;
    logic        a_mreq = 1'b0, a_write = 1'b0, a_ddt_oe, a_ackd_n, a_sv, a_halt, a_aerr;
    logic [1:0]  a_size = 2'b00;
    logic [7:0]  a_sc;

    logic [31:0] b_dad = '0, b_ddt_i = '0, b_ddt_o;
    logic        b_mreq = 1'b0, b_write = 1'b0, b_ddt_oe, b_ackd_n, b_sv, b_halt, b_aerr;
    logic [1:0]  b_size = 2'b00;
    logic [7:0]  b_sc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .DAD(a_dad), .MREQ(a_mreq), .WRITE(a_write), .SIZE(a_size),
        .DDT_I(a_ddt_i), .DDT_O(a_ddt_o), .DDT_OE(a_ddt_oe), .ACKD_n(a_ackd_n),
        .stdout_valid(a_sv), .stdout_char(a_sc), .halt(a_halt), .addr_err(a_aerr)
    );

    dmem_responder #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .DAD(b_dad), .MREQ(b_mreq), .WRITE(b_write), .SIZE(b_size),
        .DDT_I(b_ddt_i), .DDT_O(b_ddt_o), .DDT_OE(b_ddt_oe), .ACKD_n(b_ackd_n),
        .stdout_valid(b_sv), .stdout_char(b_sc), .halt(b_halt), .addr_err(b_aerr)
    );

    // One request on the selected instance; lat = negedges from acceptance to ACK, -1 if none in 20.
    task automatic access(input bit sel, input logic [31:0] addr, input bit wr,
                          input logic [1:0] sz, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic oe,
                          output logic sv, output logic [7:0] sc);
        int n;
        @(posedge clk); #1;
        if (sel) begin
            b_dad = addr; b_write = wr; b_size = sz; b_ddt_i = wd; b_mreq = 1'b1;
        end else begin
            a_dad = addr; a_write = wr; a_size = sz; a_ddt_i = wd; a_mreq = 1'b1;
        end
        @(posedge clk); #1;
        a_mreq = 1'b0;
        b_mreq = 1'b0;
        n = 1;
        @(negedge clk);
        while (((sel ? b_ackd_n : a_ackd_n) !== 1'b0) && n < 20) begin
            n++;
            @(negedge clk);
        end
        lat = ((sel ? b_ackd_n : a_ackd_n) === 1'b0) ? n : -1;
        rd  = sel ? b_ddt_o : a_ddt_o;
        oe  = sel ? b_ddt_oe : a_ddt_oe;
        sv  = sel ? b_sv : a_sv;
        sc  = sel ? b_sc : a_sc;
        @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (a_ackd_n !== 1'b1) begin bad++; $display("FAIL rst_ack1 got=%b exp=1", a_ackd_n); end
        total++; if (a_ddt_oe !== 1'b0 || a_ddt_o !== 32'h0) begin bad++; $display("FAIL rst_ddt1 got oe=%b d=%h exp 0/0", a_ddt_oe, a_ddt_o); end
        total++; if (a_sv !== 1'b0 || a_sc !== 8'h00) begin bad++; $display("FAIL rst_stdout1 got=%b/%h exp 0/00", a_sv, a_sc); end
        total++; if (a_halt !== 1'b0 || a_aerr !== 1'b0) begin bad++; $display("FAIL rst_flags1 got=%b/%b exp 0/0", a_halt, a_aerr); end
        total++; if (b_ackd_n !== 1'b1 || b_ddt_oe !== 1'b0 || b_ddt_o !== 32'h0) begin bad++; $display("FAIL rst_dut3 got ack=%b oe=%b d=%h", b_ackd_n, b_ddt_oe, b_ddt_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic oe, sv; logic [7:0] sc;
        access(0, 32'h0800_0010, 1, 2'b00, 32'h1122_3344, lat, rd, oe, sv, sc);
        total++; if (lat !== 1) begin bad++; $display("FAIL word_store_lat got=%0d exp=1", lat); end
        total++; if (oe !== 1'b0) begin bad++; $display("FAIL word_store_oe got=%b exp=0", oe); end
        access(0, 32'h0800_0010, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (lat !== 1) begin bad++; $display("FAIL word_load_lat got=%0d exp=1", lat); end
        total++; if (rd !== 32'h1122_3344 || oe !== 1'b1) begin bad++; $display("FAIL word_load got=%h oe=%b exp=11223344 oe=1", rd, oe); end
        @(negedge clk);
        total++; if (a_ddt_o !== 32'h0 || a_ackd_n !== 1'b1) begin bad++; $display("FAIL idle_ddt got=%h ack=%b exp=0 ack=1", a_ddt_o, a_ackd_n); end
    endtask

    task automatic test_lanes();
        int lat; logic [31:0] rd; logic oe, sv; logic [7:0] sc;
        access(0, 32'h0800_0011, 1, 2'b10, 32'h0000_00ab, lat, rd, oe, sv, sc);
        access(0, 32'h0800_0010, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h1122_ab44) begin bad++; $display("FAIL byte_merge got=%h exp=1122ab44", rd); end
        access(0, 32'h0800_0012, 0, 2'b01, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h0000_1122) begin bad++; $display("FAIL half_load_hi got=%h exp=00001122", rd); end
        access(0, 32'h0800_0011, 0, 2'b11, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h0000_00ab) begin bad++; $display("FAIL byte_load got=%h exp=000000ab", rd); end
        access(0, 32'h0800_0010, 1, 2'b01, 32'hffff_beef, lat, rd, oe, sv, sc);
        access(0, 32'h0800_0013, 1, 2'b10, 32'h1234_5699, lat, rd, oe, sv, sc);
        access(0, 32'h0800_0010, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h9922_beef) begin bad++; $display("FAIL half_byte_store got=%h exp=9922beef", rd); end
        access(0, 32'h0800_0013, 0, 2'b01, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h0000_9922) begin bad++; $display("FAIL misaligned_half got=%h exp=00009922", rd); end
        access(0, 32'h0800_0011, 0, 2'b10, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h0000_00be) begin bad++; $display("FAIL byte_load2 got=%h exp=000000be", rd); end
    endtask

    task automatic test_latency3();
        int lat; logic [31:0] rd, d; logic oe, sv; logic [7:0] sc;
        logic [6:0] acks, oes;
        access(1, 32'h0800_0020, 1, 2'b00, 32'hcafe_f00d, lat, rd, oe, sv, sc);
        total++; if (lat !== 3) begin bad++; $display("FAIL lat3_store got=%0d exp=3", lat); end
        @(posedge clk); #1;
        b_dad = 32'h0800_0020; b_write = 1'b0; b_size = 2'b00; b_mreq = 1'b1;
        @(posedge clk);
        d = 32'h0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            acks[i] = b_ackd_n;
            oes[i]  = b_ddt_oe;
            if (i == 2) d = b_ddt_o;
        end
        b_mreq = 1'b0;
        total++; if (acks !== 7'b0111011) begin bad++; $display("FAIL lat3_held_ack got=%b exp=0111011", acks); end
        total++; if (oes !== 7'b1000100) begin bad++; $display("FAIL lat3_held_oe got=%b exp=1000100", oes); end
        total++; if (d !== 32'hcafe_f00d) begin bad++; $display("FAIL lat3_load got=%h exp=cafef00d", d); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_addr_err();
        int lat; logic [31:0] rd; logic oe, sv; logic [7:0] sc;
        access(0, 32'h0800_0000, 1, 2'b00, 32'h0102_0304, lat, rd, oe, sv, sc);
        access(0, 32'h0800_3ffc, 1, 2'b00, 32'h5a5a_5a5a, lat, rd, oe, sv, sc);
        access(0, 32'h0800_3ffc, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h5a5a_5a5a) begin bad++; $display("FAIL last_word got=%h exp=5a5a5a5a", rd); end
        @(negedge clk);
        total++; if (a_aerr !== 1'b0) begin bad++; $display("FAIL aerr_in_window got=%b exp=0", a_aerr); end
        access(0, 32'h0800_4000, 1, 2'b00, 32'h7777_7777, lat, rd, oe, sv, sc);
        total++; if (lat !== 1) begin bad++; $display("FAIL oow_store_lat got=%0d exp=1", lat); end
        @(negedge clk);
        total++; if (a_aerr !== 1'b1) begin bad++; $display("FAIL aerr_past_end got=%b exp=1", a_aerr); end
        access(0, 32'h0800_0000, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h0102_0304) begin bad++; $display("FAIL no_wrap_write got=%h exp=01020304", rd); end
        access(0, 32'h0000_0100, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (lat !== 1 || rd !== 32'h0 || oe !== 1'b1) begin bad++; $display("FAIL oow_load got lat=%0d d=%h oe=%b exp 1/0/1", lat, rd, oe); end
        @(negedge clk);
        total++; if (a_aerr !== 1'b1) begin bad++; $display("FAIL aerr_sticky got=%b exp=1", a_aerr); end
    endtask

    task automatic test_reset_mid();
        int lat; int acks_seen; logic [31:0] rd; logic oe, sv; logic [7:0] sc;
        access(1, 32'h0800_0030, 1, 2'b00, 32'h1234_5678, lat, rd, oe, sv, sc);
        @(posedge clk); #1;
        b_dad = 32'h0800_0030; b_write = 1'b1; b_size = 2'b00; b_ddt_i = 32'hdead_beef; b_mreq = 1'b1;
        @(posedge clk); #1;
        b_mreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (b_ackd_n !== 1'b1 || b_ddt_oe !== 1'b0 || b_ddt_o !== 32'h0) begin bad++; $display("FAIL rstmid_outs got ack=%b oe=%b d=%h", b_ackd_n, b_ddt_oe, b_ddt_o); end
        total++; if (b_sv !== 1'b0 || b_sc !== 8'h00 || b_halt !== 1'b0 || b_aerr !== 1'b0) begin bad++; $display("FAIL rstmid_flags got sv=%b sc=%h h=%b e=%b", b_sv, b_sc, b_halt, b_aerr); end
        total++; if (a_aerr !== 1'b0) begin bad++; $display("FAIL rstmid_aerr_clr got=%b exp=0", a_aerr); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        acks_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b_ackd_n !== 1'b1) acks_seen++;
        end
        total++; if (acks_seen !== 0) begin bad++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks_seen); end
        access(1, 32'h0800_0030, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL rstmid_no_write got=%h exp=12345678", rd); end
    endtask

    task automatic test_stdout();
        int lat; logic [31:0] rd; logic oe, sv; logic [7:0] sc;
        access(0, 32'hf000_0000, 1, 2'b10, 32'h0000_0041, lat, rd, oe, sv, sc);
        total++; if (lat !== 1 || sv !== 1'b1 || sc !== 8'h41) begin bad++; $display("FAIL stdout_byte got lat=%0d v=%b c=%h exp 1/1/41", lat, sv, sc); end
        @(negedge clk);
        total++; if (a_sv !== 1'b0 || a_sc !== 8'h00) begin bad++; $display("FAIL stdout_one_cycle got=%b/%h exp 0/00", a_sv, a_sc); end
        access(0, 32'hf000_0000, 1, 2'b00, 32'h0000_0042, lat, rd, oe, sv, sc);
        total++; if (lat !== 1 || sv !== 1'b0) begin bad++; $display("FAIL stdout_word_drop got lat=%0d v=%b exp 1/0", lat, sv); end
        access(0, 32'h0800_0010, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (rd !== 32'h9922_beef) begin bad++; $display("FAIL stdout_ram_kept got=%h exp=9922beef", rd); end
        @(negedge clk);
        total++; if (a_aerr !== 1'b0) begin bad++; $display("FAIL stdout_no_aerr got=%b exp=0", a_aerr); end
    endtask

    task automatic test_halt();
        int lat; logic [31:0] rd; logic oe, sv; logic [7:0] sc;
        access(0, 32'hff00_0000, 1, 2'b00, 32'h0000_0000, lat, rd, oe, sv, sc);
        total++; if (lat !== 1) begin bad++; $display("FAIL exit_ack got=%0d exp=1", lat); end
        @(negedge clk);
        total++; if (a_halt !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", a_halt); end
        access(0, 32'h0800_0010, 0, 2'b00, 32'h0, lat, rd, oe, sv, sc);
        total++; if (lat !== -1) begin bad++; $display("FAIL halted_no_ack got=%0d exp=-1", lat); end
        total++; if (a_halt !== 1'b1 || a_aerr !== 1'b0) begin bad++; $display("FAIL halted_flags got=%b/%b exp 1/0", a_halt, a_aerr); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_latency3();
        test_addr_err();
        test_reset_mid();
        test_stdout();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
